// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory for the MEM stage: valid/ready requests,
// byte/half/word accesses with sign/zero extension and a fixed read latency.
module data_memory_ctrl #(
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 2,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [7:0]       mem [0:DEPTH-1];

    logic              accept;
    logic              err_p0;
    logic [2:0]        nbytes_p0;
    logic [ADDR_W:0]   last_byte_p0;
    logic [IDX_W-1:0]  idx0_p0, idx1_p0, idx2_p0, idx3_p0;
    logic [DATA_W-1:0] raw_p0;
    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;
    logic              resp_valid_next, resp_err_next;
    logic [DATA_W-1:0] resp_rdata_next;

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                                 input logic [1:0] size,
                                                 input logic sgn);
        case (size)
            2'd0:    extend = {{24{sgn & raw[7]}}, raw[7:0]};
            2'd1:    extend = {{16{sgn & raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid & req_ready & ~reset;

    always_comb begin
        case (req_size)
            2'd0:    nbytes_p0 = 3'd1;
            2'd1:    nbytes_p0 = 3'd2;
            default: nbytes_p0 = 3'd4;
        endcase
    end

    // One extra bit so an access near the top of the address space cannot wrap into range.
    assign last_byte_p0 = {1'b0, req_addr} + (ADDR_W+1)'(nbytes_p0) - (ADDR_W+1)'(1);
    assign err_p0 = (req_size == 2'd3)
                  | ((req_size == 2'd1) & req_addr[0])
                  | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00))
                  | (last_byte_p0 >= (ADDR_W+1)'(DEPTH));

    assign idx0_p0 = req_addr[IDX_W-1:0];
    assign idx1_p0 = idx0_p0 + IDX_W'(1);
    assign idx2_p0 = idx0_p0 + IDX_W'(2);
    assign idx3_p0 = idx0_p0 + IDX_W'(3);

    always_comb begin
        case (req_size)
            2'd0:    raw_p0 = {24'b0, mem[idx0_p0]};
            2'd1:    raw_p0 = {16'b0, mem[idx0_p0], mem[idx1_p0]};
            default: raw_p0 = {mem[idx0_p0], mem[idx1_p0], mem[idx2_p0], mem[idx3_p0]};
        endcase
    end

    // Stage p0 -> p1: stores commit and load data is captured at the accept edge.
    always_ff @(posedge clock) begin
        if (accept & req_write & ~err_p0) begin
            case (req_size)
                2'd0: mem[idx0_p0] <= req_wdata[7:0];
                2'd1: begin
                    mem[idx0_p0] <= req_wdata[15:8];
                    mem[idx1_p0] <= req_wdata[7:0];
                end
                default: begin
                    mem[idx0_p0] <= req_wdata[31:24];
                    mem[idx1_p0] <= req_wdata[23:16];
                    mem[idx2_p0] <= req_wdata[15:8];
                    mem[idx3_p0] <= req_wdata[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            rdata_p1 <= (err_p0 | req_write) ? '0 : extend(raw_p0, req_size, req_signed);
            err_p1   <= err_p0;
        end
    end

    always_comb begin
        state_next      = state;
        count_next      = count;
        resp_valid_next = 1'b0;
        resp_rdata_next = '0;
        resp_err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_write) begin
                        state_next = WR_RESP;
                    end else begin
                        state_next = RD_WAIT;
                        count_next = CNT_W'(READ_LAT - 1);
                    end
                end
            end
            WR_RESP: begin
                state_next      = IDLE;
                resp_valid_next = 1'b1;
                resp_err_next   = err_p1;
            end
            RD_WAIT: begin
                if (count == '0) begin
                    state_next      = IDLE;
                    resp_valid_next = 1'b1;
                    resp_rdata_next = rdata_p1;
                    resp_err_next   = err_p1;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p1 -> response: registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            resp_valid <= resp_valid_next;
            resp_rdata <= resp_rdata_next;
            resp_err   <= resp_err_next;
        end
    end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Byte-addressed, big-endian data memory for the pipeline MEM stage; successor to the fixed 32-bit word memory.
- Parametrised depth and read latency, with byte/half/word access sizes and signed/unsigned load extension.
- Uses a valid/ready request port and a response port, so the stall logic can wait for multi-cycle loads.
- Flags misaligned, out-of-range and reserved-size accesses instead of silently corrupting memory.

Parameters:
- DEPTH, 1024, memory size in bytes; power of two, >= 4.
- ADDR_W, 32, width of req_addr.
- READ_LAT, 2, cycles from request accept to load response; >= 1.
- DATA_W, 32, data width; fixed at 32 (legal value only).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low 8/16/32 bits are used, per size.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  sign-extend loaded byte/half.
- resp_valid  out  1  one-cycle pulse; response for the accepted request.
- resp_rdata  out  32  load data, zero/sign-extended; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; access was rejected.
- busy  out  1  request outstanding (equals ~req_ready).

Behaviour:
- Storage is reg [7:0] mem[0:DEPTH-1], big-endian: the byte at addr is the MSB of a word/half. Contents are not cleared by reset.
- Reset (clock and reset as decided: reset synchronous active-high, clock clock):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, counter = 0.
- Handshake:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - One request is outstanding at a time; req_ready is 0 from the cycle after accept until the cycle after resp_valid.
  - Request fields are captured at accept; later changes have no effect.
- Error check, computed at accept; err = 1 if any of:
  - req_size == 3;
  - half with addr[0] == 1;
  - word with addr[1:0] != 0;
  - addr + bytes - 1 >= DEPTH, computed without wrap at ADDR_W+1 bits.
  - An erroring store writes nothing. An erroring load returns rdata = 0.
- FSM states and transitions:
  - IDLE: on accept, go to WR_RESP if store, else to RD_WAIT with counter = READ_LAT-1.
  - WR_RESP: memory bytes were written at the accept edge. resp_valid = 1, rdata = 0, err = the check result for one cycle. Then IDLE. Store latency is always 1.
  - RD_WAIT: memory bytes are sampled at the accept edge into a held register. Decrement the counter each cycle. When the counter == 0, drive resp_valid with the extended data and go to IDLE. Load response appears exactly READ_LAT cycles after the accept edge.
  - With READ_LAT = 1, RD_WAIT is entered with counter 0 and responds on the next cycle.
- Extension: byte/half are zero-extended unless req_signed; word ignores req_signed.
- Back-to-back: a new request may be accepted in the cycle after resp_valid (IDLE again). A load after a store to the same address sees the stored data.
- Reset mid-operation:
  - The outstanding load is dropped with no response.
  - An already-accepted store stays committed.
  - Outputs return to reset values at the next edge.
- resp_valid never asserts without a prior accept. Outputs are registered.

Test Plan:
- Reset, then word store addr 0x10 data 0xDEADBEEF; load word 0x10 -> resp_err 0, resp_rdata 0xDEADBEEF exactly READ_LAT=2 cycles after accept; mem[0x10] = 0xDE (big-endian).
- After the above, load byte 0x13 unsigned -> 0x000000EF; signed -> 0xFFFFFFEF; load half 0x10 signed -> 0xFFFFDEAD, unsigned -> 0x0000DEAD.
- Store byte 0x11 data 0x00000055, then load word 0x10 -> 0xDE55BEEF; the other bytes are unchanged.
- Misaligned store word 0x12 data 0x12345678 -> resp_err 1 after 1 cycle, rdata 0; a subsequent load word 0x10 still returns 0xDE55BEEF. Load word at DEPTH-2 -> err 1. req_size 3 -> err 1.
- Hold req_valid high with 4 consecutive loads -> req_ready 0 while outstanding; exactly 4 resp_valid pulses, each spaced READ_LAT+1 cycles apart, in order.
- Accept a load, then assert reset the next cycle -> no resp_valid; req_ready = 1 and resp_rdata = 0 after the reset edge; memory contents intact (load word 0x10 -> 0xDE55BEEF).
